// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside the decode stage of the 5-stage RV32 core: detects RAW
// hazards against the EX producer, sequences multi-cycle stalls, flushes on jumps.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_branch,
    input  logic             id_jump,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(LOAD_LAT);
    localparam logic [3:0] LAT_LOADBR = 4'(LOAD_LAT + 1);

    state_t     state, state_next;
    logic [3:0] rem, rem_next;
    logic       rs1_match, rs2_match, hit;
    logic [3:0] need;
    logic       stall_inc, flush_inc;

    assign rs1_match = (ex_rd != 5'd0) && (ex_rd == id_rs1) && id_use_rs1;
    assign rs2_match = (ex_rd != 5'd0) && (ex_rd == id_rs2) && id_use_rs2;
    assign hit       = id_valid && ex_reg_write && (rs1_match || rs2_match);
    assign state_dbg = state;

    // Stall length; an ALU producer feeding a non-branch consumer is covered by forwarding.
    always_comb begin
        need = 4'd0;
        if (hit) begin
            case ({ex_mem_read, id_is_branch})
                2'b11:   need = LAT_LOADBR;
                2'b10:   need = LAT_LOAD;
                2'b01:   need = 4'd1;
                default: need = 4'd0;
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_next   = state;
        rem_next     = rem;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (state == STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            rem_next     = rem - 4'd1;
            if (rem == 4'd1) begin
                state_next = RUN;
            end
        end else if (need != 4'd0) begin
            // The jump is ignored here: its operands are stale and ID re-presents it.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (need > 4'd1) begin
                state_next = STALL;
                rem_next   = need - 4'd1;
            end
        end else if (id_jump && id_valid) begin
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            rem       <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=4)
// share stimulus and are checked each cycle against a stall-countdown model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_is_branch, id_jump;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_reg_write, ex_mem_read, mem_busy;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble;
    logic [1:0]  a_state_dbg;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble;
    logic [1:0]  b_state_dbg;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Model state per instance: stall cycles still owed, and the two counters.
    int m_rem[2];
    int m_stall[2];
    int m_flush[2];
    int lat[2]    = '{1, 3};
    int cnt_max[2] = '{65535, 15};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_branch(id_is_branch),
        .id_jump(id_jump), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_busy(mem_busy), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
        .if_id_flush(a_if_id_flush), .id_ex_bubble(a_id_ex_bubble), .state_dbg(a_state_dbg),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_branch(id_is_branch),
        .id_jump(id_jump), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_busy(mem_busy), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
        .if_id_flush(b_if_id_flush), .id_ex_bubble(b_id_ex_bubble), .state_dbg(b_state_dbg),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Cycle class: 0 reset, 1 freeze, 2 stall, 3 flush, 4 run.
    function automatic int classify(int i, output int n);
        bit m1, m2, hit;
        m1  = (ex_rd != 0) && (ex_rd == id_rs1) && id_use_rs1;
        m2  = (ex_rd != 0) && (ex_rd == id_rs2) && id_use_rs2;
        hit = id_valid && ex_reg_write && (m1 || m2);
        n = 0;
        if (hit) n = ex_mem_read ? lat[i] + (id_is_branch ? 1 : 0) : (id_is_branch ? 1 : 0);
        if (reset) return 0;
        if (mem_busy) return 1;
        if (m_rem[i] > 0 || n > 0) return 2;
        if (id_jump && id_valid) return 3;
        return 4;
    endfunction

    task automatic applyStimulus(input bit rst, input bit vld, input int rs1, input int rs2,
                                 input bit u1, input bit u2, input bit br, input bit jmp,
                                 input int rd, input bit rw, input bit mr, input bit busy);
        reset = rst; id_valid = vld; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_is_branch = br; id_jump = jmp;
        ex_rd = 5'(rd); ex_reg_write = rw; ex_mem_read = mr; mem_busy = busy;
        #1;
    endtask

    task automatic checkOutput();
        logic [37:0] exp_v, act_v;
        int cls, n;
        logic [3:0] ctl;
        for (int i = 0; i < 2; i++) begin
            cls = classify(i, n);
            case (cls)
                0: ctl = 4'b0001;
                1: ctl = 4'b0000;
                2: ctl = 4'b0001;
                3: ctl = 4'b1110;
                default: ctl = 4'b1100;
            endcase
            exp_v = {ctl, (m_rem[i] > 0) ? 2'd1 : 2'd0, 16'(m_stall[i]), 16'(m_flush[i])};
            if (i == 0)
                act_v = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_state_dbg,
                         a_stall_cnt, a_flush_cnt};
            else
                act_v = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_state_dbg,
                         12'd0, b_stall_cnt, 12'd0, b_flush_cnt};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL cycle_%s t=%0t got ctl=%b st=%0d sc=%0d fc=%0d want ctl=%b st=%0d sc=%0d fc=%0d",
                         (i == 0) ? "a" : "b", $time, act_v[37:34], act_v[33:32], act_v[31:16],
                         act_v[15:0], exp_v[37:34], exp_v[33:32], exp_v[31:16], exp_v[15:0]);
            end
        end
    endtask

    task automatic stepModel();
        int cls, n;
        for (int i = 0; i < 2; i++) begin
            cls = classify(i, n);
            if (cls == 0) begin
                m_rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else if (cls == 2) begin
                if (m_stall[i] < cnt_max[i]) m_stall[i]++;
                m_rem[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : n - 1;
            end else if (cls == 3) begin
                if (m_flush[i] < cnt_max[i]) m_flush[i]++;
            end
        end
    endtask

    task automatic runCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        stepModel();
        #1;
    endtask

    task automatic checkLiteral(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        runCycle();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
        doReset();
        checkLiteral("reset_stall_cnt", a_stall_cnt, 0);
        checkLiteral("reset_state", a_state_dbg, 0);

        // Load x5 feeding add x6,x5,x1.
        applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 5, 1, 1, 0);
        checkLiteral("loaduse_pc", a_pc_write, 0);
        checkLiteral("loaduse_bubble", a_id_ex_bubble, 1);
        runCycle();
        applyStimulus(0, 1, 5, 1, 1, 0, 0, 0, 5, 0, 0, 0);
        checkLiteral("loaduse_resume_pc", a_pc_write, 1);
        runCycle();
        checkLiteral("loaduse_stall_cnt", a_stall_cnt, 1);

        // Load x5 feeding beq x5,x2 with a jump request that must be ignored.
        doReset();
        applyStimulus(0, 1, 5, 2, 1, 1, 1, 1, 5, 1, 1, 0);
        checkLiteral("ldbr_flush", a_if_id_flush, 0);
        runCycle();
        checkLiteral("ldbr_state1", a_state_dbg, 1);
        checkLiteral("ldbr_flush2", a_if_id_flush, 0);
        runCycle();
        checkLiteral("ldbr_state0", a_state_dbg, 0);
        checkLiteral("ldbr_stall_cnt", a_stall_cnt, 2);
        checkLiteral("ldbr_flush_cnt", a_flush_cnt, 0);

        // x0 never hazards; ALU x7 feeding a branch stalls once.
        doReset();
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        checkLiteral("x0_pc", a_pc_write, 1);
        runCycle();
        applyStimulus(0, 1, 0, 7, 0, 1, 1, 0, 7, 1, 0, 0);
        checkLiteral("alubr_pc", a_pc_write, 0);
        runCycle();
        applyStimulus(0, 1, 0, 7, 0, 1, 1, 0, 7, 0, 0, 0);
        checkLiteral("alubr_resume_pc", a_pc_write, 1);
        runCycle();
        checkLiteral("alubr_stall_cnt", a_stall_cnt, 1);

        // Jump with no hazard flushes; jump with load-use hazard only stalls.
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkLiteral("jal_flush", a_if_id_flush, 1);
        checkLiteral("jal_pc", a_pc_write, 1);
        runCycle();
        idle();
        runCycle();
        checkLiteral("jal_flush_cnt", a_flush_cnt, 1);
        applyStimulus(0, 1, 5, 0, 1, 0, 0, 1, 5, 1, 1, 0);
        checkLiteral("jalhaz_flush", a_if_id_flush, 0);
        runCycle();
        idle();
        checkLiteral("jalhaz_flush_cnt", a_flush_cnt, 1);
        checkLiteral("jalhaz_stall_cnt", a_stall_cnt, 1);

        // Freeze for 3 cycles in the middle of a 2-cycle stall.
        doReset();
        applyStimulus(0, 1, 5, 2, 1, 1, 1, 0, 5, 1, 1, 0);
        runCycle();
        applyStimulus(0, 1, 5, 2, 1, 1, 1, 0, 5, 1, 1, 1);
        checkLiteral("frz_pc", a_pc_write, 0);
        checkLiteral("frz_ifid", a_if_id_write, 0);
        checkLiteral("frz_bubble", a_id_ex_bubble, 0);
        repeat (3) runCycle();
        checkLiteral("frz_state", a_state_dbg, 1);
        checkLiteral("frz_stall_cnt", a_stall_cnt, 1);
        applyStimulus(0, 1, 5, 2, 1, 1, 1, 0, 5, 1, 1, 0);
        runCycle();
        idle();
        checkLiteral("frz_end_state", a_state_dbg, 0);
        checkLiteral("frz_end_stall_cnt", a_stall_cnt, 2);

        // Reset while stalling abandons the stall.
        doReset();
        applyStimulus(0, 1, 5, 2, 1, 1, 1, 0, 5, 1, 1, 0);
        runCycle();
        checkLiteral("rst_mid_state1", a_state_dbg, 1);
        applyStimulus(1, 1, 5, 2, 1, 1, 1, 0, 5, 1, 1, 0);
        runCycle();
        idle();
        checkLiteral("rst_mid_state0", a_state_dbg, 0);
        checkLiteral("rst_mid_stall_cnt", a_stall_cnt, 0);

        // Continuous load-use hazard: the 4-bit counter saturates.
        doReset();
        applyStimulus(0, 1, 5, 0, 1, 0, 0, 0, 5, 1, 1, 0);
        repeat (40) runCycle();
        idle();
        checkLiteral("sat_b_stall_cnt", b_stall_cnt, 15);
        checkLiteral("sat_a_stall_cnt", a_stall_cnt, 40);

        // Randomized traffic over a small register set to provoke frequent matches.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          ($urandom_range(0, 7) == 0));
            runCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core, sitting beside the decode stage. The decode stage resolves branches and jumps and reads operands in ID. This block detects read-after-write hazards against the EX-stage producer and sequences multi-cycle stalls. It also flushes the IF/ID register on a taken jump and freezes the whole pipe while data memory is busy. It keeps saturating performance counters for stall and flush events.

Parameters:
LOAD_LAT, 1, extra stall cycles for a load-use hazard with a non-branch consumer (1..7)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  single clock, all state updates on its rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_is_branch  in  1  ID instruction compares operands in ID (branch/JALR)
id_jump  in  1  ID redirect taken (control_j)
ex_rd  in  5  EX destination register
ex_reg_write  in  1  EX writes a register
ex_mem_read  in  1  EX is a load
mem_busy  in  1  data memory not ready; freeze request
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_bubble  out  1  ID/EX control field loads zero
state_dbg  out  2  current state: 0 RUN, 1 STALL
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flushes

Behaviour:
- Reset (sync, high) puts the block in RUN and clears the remaining-stall counter rem, stall_cnt and flush_cnt.
- Output values while reset is high: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1.
- A register match requires all of: ex_rd!=0, ex_rd equal to the source register, and that source's use bit set.
- hit = id_valid & ex_reg_write & (rs1 match | rs2 match).
- Required stall length N, computed only when hit=1 in RUN:
  - ex_mem_read & id_is_branch: N = LOAD_LAT+1
  - ex_mem_read & !id_is_branch: N = LOAD_LAT
  - !ex_mem_read & id_is_branch: N = 1
  - otherwise: N = 0 and there is no hazard (the forwarding path covers it).
- Outputs are Mealy and combinational from state plus inputs. Priority is freeze > stall > jump.
- FREEZE (mem_busy=1, any state):
  - all four control outputs are 0.
  - state and rem hold, and no counter changes.
- RUN, hazard (N>0):
  - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - stall_cnt increments.
  - if N>1, next state is STALL with rem=N-1; if N=1, the block stays in RUN.
  - id_jump is ignored this cycle because its operands are stale; ID re-presents the instruction.
- RUN, no hazard, id_jump=1 and id_valid=1:
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
  - flush_cnt increments.
- RUN, otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- STALL:
  - outputs are the same as a RUN hazard cycle, and stall_cnt increments.
  - hazard inputs and id_jump are ignored.
  - rem decrements each cycle; when rem==1 the next state is RUN.
  - the total stall is exactly N consecutive non-frozen cycles.
- Counters saturate at all-ones and do not wrap.
- A freeze mid-STALL extends the wall-clock duration but not the number of non-frozen stall cycles.
- Reset asserted mid-STALL forces RUN the next cycle; the stall is abandoned.

Test Plan:
- Load x5 in EX, ID `add x6,x5,x1` with use_rs1=1, LOAD_LAT=1 -> 1 cycle with pc_write=0 and id_ex_bubble=1, then normal; stall_cnt=1.
- Load x5 in EX, ID `beq x5,x2` with is_branch=1 -> 2 stall cycles, state_dbg 0→1→0; stall_cnt=2; id_jump ignored during both cycles.
- ALU writes x0 in EX, ID reads x0 -> no stall. ALU writes x7, ID branch on x7 -> 1 stall cycle.
- ID jal, no hazard, id_jump=1 -> if_id_flush=1 for one cycle with pc_write=1; flush_cnt=1. With a simultaneous load-use hazard -> stall only, flush_cnt unchanged.
- mem_busy high for 3 cycles in the middle of a 2-cycle stall -> all enables 0 for those 3 cycles; total stall cycles still 2; stall_cnt=2.
- Preload the counter to all-ones via 2^CNT_W stalls (CNT_W=4 variant) -> stall_cnt holds 15. Reset during STALL -> RUN with counters 0.
